data_memory_unit: RTL and testbench
===================================

Name: data_memory_unit

Overview:
- Parametrised, byte-addressed, big-endian data memory for the MIPS datapath.
- Replaces the single-cycle combinational-read data memory.
- Adds a valid/ready request/response handshake, a configurable access latency and byte/half/word access sizes with sign or zero extension.
- Flags misaligned and out-of-range accesses.
- Sits between the ALU result / rt read data and the register-file write-back mux; lets a multi-cycle or stalled core tolerate slow memory.

Parameters:
- DEPTH_BYTES, 1024: memory size in bytes; power of two, at least 4.
- LATENCY, 2: clock edges from request acceptance to rsp_valid; at least 1.
- ADDR_W, 32: request address width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_unsigned  input  1  load zero-extends when 1 (LBU/LHU); ignored for stores and word loads.
- req_address  input  ADDR_W  byte address.
- req_wdata  input  32  store data; low-order bytes used for byte/half stores.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_error  output  1  misaligned, reserved size or out-of-range access.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state IDLE, req_ready=0 while reset is high and 1 after release, rsp_valid=0, rsp_rdata=0, rsp_error=0, latency counter 0. Memory array is not cleared by reset; it is zero-initialised at time 0.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready at edge N, latch the request and go to WAIT with counter=LATENCY-1. When LATENCY=1, go directly to RESP.
  - WAIT: req_ready=0. Decrement the counter each edge; go to RESP when it reaches 0.
  - RESP: rsp_valid=1; rsp_rdata and rsp_error are stable. On rsp_valid&&rsp_ready, go to IDLE. Hold indefinitely while rsp_ready=0.
- Latency: rsp_valid first rises after edge N+LATENCY.
- Throughput: one outstanding transaction. No same-cycle response-to-request overlap; req_ready returns the cycle after the response handshake.
- Error check, evaluated on the latched request:
  - size=3: error.
  - half with address[0]≠0: error.
  - word with address[1:0]≠0: error.
  - address+bytes > DEPTH_BYTES: error. Compute in ADDR_W+1 bits so there is no wrap-around.
  - On error: no memory write, rsp_rdata=0, rsp_error=1.
- Store: bytes are committed at edge N (acceptance), big-endian. mem[a] gets the MSB of the stored field.
  - Word: mem[a..a+3] = wdata[31:24], [23:16], [15:8], [7:0].
  - Half: mem[a..a+1] = wdata[15:8], [7:0].
  - Byte: mem[a] = wdata[7:0].
- Load data: read at edge N+LATENCY from the array.
  - Byte: {24 ext, mem[a]}.
  - Half: {16 ext, mem[a], mem[a+1]}.
  - Sign bit is bit 7 of mem[a]; ext = 0 when req_unsigned=1.
- Input stability: request inputs are ignored outside IDLE; changes while busy have no effect.
- Reset mid-operation: the transaction is dropped and no response is issued. A store already committed at acceptance remains in memory.
- Address bits above log2(DEPTH_BYTES) matter only through the range check.

Decomposition:
- Shared package (mem_pkg) holds:
  - Size encodings SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2.
  - State enum IDLE/WAIT/RESP.
  - A function computing the byte count from the size.
- One natural sub-module, mem_load_align: purely combinational. Takes the four fetched bytes, size and unsigned flag; produces the extended rsp_rdata. It is reused later by a cache-fill path.
- The FSM, counter and storage array stay in the top module.

Test Plan:
- Word round-trip, LATENCY=2:
  - Store word 0x12345678 at 0x10; rsp_valid follows 2 edges after acceptance with rsp_error=0 and rsp_rdata=0.
  - Load word at 0x10 returns 0x12345678.
- Sign/zero extension:
  - After the word store above, load half signed at 0x12 returns 0x00005678.
  - Store byte 0xF0 at 0x13; load byte signed at 0x13 returns 0xFFFFFFF0; load byte unsigned returns 0x000000F0.
  - Load half signed at 0x12 returns 0x000056F0.
- Errors:
  - Word load at 0x11 returns rsp_error=1 and rdata=0.
  - Half store at 0x3FF returns error and mem[0x3FF] is unchanged.
  - Word access at 0x3FC succeeds.
  - Size 3 returns error.
- Backpressure: hold rsp_ready=0 for 5 cycles. rsp_valid and data stay stable, req_ready stays 0, and a new req_valid is not accepted.
- Reset mid-WAIT:
  - Assert reset one cycle after accepting a store of 0xAABBCCDD at 0x20. No rsp_valid appears and outputs are 0.
  - After release, req_ready=1 and a load at 0x20 returns 0xAABBCCDD.
- Parameter sweep: LATENCY=1 and LATENCY=5 with DEPTH_BYTES=64. Latency is exact, and the address 0x40 range check errors.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory unit: access-size encodings, FSM states
// and the byte-count helper used by the range check.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // The reserved size reports 4 bytes, but it is always flagged as an error anyway.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Turns four big-endian fetched bytes (fetch[31:24] = mem[a]) into sign- or
// zero-extended load data for byte, half and word accesses.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] fetch,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] rdata
);

  logic ext_bit;

  assign ext_bit = ~is_unsigned & fetch[31];

  always_comb begin
    rdata = '0;
    case (size)
      SIZE_BYTE: rdata = {{24{ext_bit}}, fetch[31:24]};
      SIZE_HALF: rdata = {{16{ext_bit}}, fetch[31:16]};
      SIZE_WORD: rdata = fetch;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_unit.sv
// Byte-addressed big-endian data memory with a valid/ready handshake, fixed
// access latency, and misalignment / range error reporting.
module data_memory_unit
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int EXT_W = ADDR_W + 1;

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             load_rsp;
  logic             accept;

  logic             lat_write;
  logic [1:0]       lat_size;
  logic             lat_unsigned;
  logic             lat_error;
  logic [IDX_W-1:0] lat_index;

  logic [EXT_W-1:0] end_addr;
  logic             req_error;
  logic [IDX_W-1:0] req_index;
  logic [31:0]      fetch;
  logic [31:0]      aligned;

  logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};

  assign req_ready = (state == IDLE) && !reset;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign req_index = req_address[IDX_W-1:0];

  // The request is only ever checked at acceptance and the verdict is latched, so
  // the store can be suppressed in the same edge that commits it.
  assign end_addr  = {1'b0, req_address} + EXT_W'(size_bytes(req_size));
  assign req_error = (req_size == 2'd3)
                   || (req_size == SIZE_HALF && req_address[0])
                   || (req_size == SIZE_WORD && req_address[1:0] != 2'b00)
                   || (end_addr > EXT_W'(DEPTH_BYTES));

  always_comb begin
    state_next = state;
    count_next = count;
    load_rsp   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = WAIT;
          count_next = CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (count == '0) begin
          state_next = RESP;
          load_rsp   = 1'b1;
        end else begin
          count_next = count - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      lat_write    <= 1'b0;
      lat_size     <= SIZE_BYTE;
      lat_unsigned <= 1'b0;
      lat_error    <= 1'b0;
      lat_index    <= '0;
      rsp_rdata    <= '0;
      rsp_error    <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (accept) begin
        lat_write    <= req_write;
        lat_size     <= req_size;
        lat_unsigned <= req_unsigned;
        lat_error    <= req_error;
        lat_index    <= req_index;
      end
      if (load_rsp) begin
        rsp_error <= lat_error;
        rsp_rdata <= (lat_error || lat_write) ? 32'h0 : aligned;
      end
    end
  end

  // Storage has no reset: contents survive reset, and stores commit at acceptance.
  always_ff @(posedge clk) begin
    if (accept && req_write && !req_error) begin
      case (req_size)
        SIZE_BYTE: mem[req_index] <= req_wdata[7:0];
        SIZE_HALF: begin
          mem[req_index]              <= req_wdata[15:8];
          mem[req_index + IDX_W'(1)]  <= req_wdata[7:0];
        end
        default: begin
          mem[req_index]              <= req_wdata[31:24];
          mem[req_index + IDX_W'(1)]  <= req_wdata[23:16];
          mem[req_index + IDX_W'(2)]  <= req_wdata[15:8];
          mem[req_index + IDX_W'(3)]  <= req_wdata[7:0];
        end
      endcase
    end
  end

  assign fetch = {mem[lat_index],
                  mem[lat_index + IDX_W'(1)],
                  mem[lat_index + IDX_W'(2)],
                  mem[lat_index + IDX_W'(3)]};

  mem_load_align u_load_align (
    .fetch       (fetch),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .rdata       (aligned)
  );

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: three instances (1024B/L2, 64B/L1, 64B/L5) driven by
// directed and random transactions checked against a byte-array reference model.
module tb_data_memory_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic        req_valid    [3];
  logic        req_write    [3];
  logic [1:0]  req_size     [3];
  logic        req_unsigned [3];
  logic [31:0] req_address  [3];
  logic [31:0] req_wdata    [3];
  logic        rsp_ready    [3];
  logic        req_ready    [3];
  logic        rsp_valid    [3];
  logic [31:0] rsp_rdata    [3];
  logic        rsp_error    [3];

  data_memory_unit #(.DEPTH_BYTES(1024), .LATENCY(2), .ADDR_W(32)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_address(req_address[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]));

  data_memory_unit #(.DEPTH_BYTES(64), .LATENCY(1), .ADDR_W(32)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_address(req_address[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]));

  data_memory_unit #(.DEPTH_BYTES(64), .LATENCY(5), .ADDR_W(32)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
    .req_size(req_size[2]), .req_unsigned(req_unsigned[2]), .req_address(req_address[2]),
    .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_error(rsp_error[2]));

  int total = 0;
  int bad   = 0;
  logic [7:0] model [3][1024];

  function automatic int latOf(input int id);
    return (id == 0) ? 2 : (id == 1) ? 1 : 5;
  endfunction

  function automatic int depthOf(input int id);
    return (id == 0) ? 1024 : 64;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction on instance id; optionally stalls the response for hold cycles
  // while pushing a stray store that must be ignored.
  task automatic applyStimulus(input int id, input logic write, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata, input int hold);
    int          nbytes;
    logic [32:0] end_addr;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [15:0] h;
    logic [7:0]  b;
    int          edges;
    int          a;

    nbytes   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    end_addr = {1'b0, addr} + 33'(nbytes);
    exp_err  = (size == 2'd3) || (size == 2'd1 && addr[0] != 1'b0)
            || (size == 2'd2 && addr[1:0] != 2'b00) || (end_addr > 33'(depthOf(id)));
    exp_data = 32'h0;
    a = int'(addr);
    if (!exp_err && write) begin
      for (int k = 0; k < nbytes; k++)
        model[id][a + k] = 8'(wdata >> (8 * (nbytes - 1 - k)));
    end else if (!exp_err) begin
      b = model[id][a];
      h = {model[id][a], model[id][a + 1]};
      case (size)
        2'd0: exp_data = uns ? 32'(b) : 32'($signed(b));
        2'd1: exp_data = uns ? 32'(h) : 32'($signed(h));
        default: exp_data = {model[id][a], model[id][a + 1], model[id][a + 2], model[id][a + 3]};
      endcase
    end

    @(negedge clk);
    checkOutput($sformatf("d%0d_ready_idle", id), 32'(req_ready[id]), 32'h1);
    req_valid[id]    = 1'b1;
    req_write[id]    = write;
    req_size[id]     = size;
    req_unsigned[id] = uns;
    req_address[id]  = addr;
    req_wdata[id]    = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid[id]    = 1'b0;
    req_write[id]    = ~write;
    req_size[id]     = 2'($urandom_range(0, 3));
    req_address[id]  = $urandom;
    req_wdata[id]    = $urandom;
    checkOutput($sformatf("d%0d_ready_busy", id), 32'(req_ready[id]), 32'h0);
    edges = 0;
    while (!rsp_valid[id] && edges < 40) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    checkOutput($sformatf("d%0d_latency", id), 32'(edges), 32'(latOf(id)));
    checkOutput($sformatf("d%0d_rdata@%0h", id, addr), rsp_rdata[id], exp_data);
    checkOutput($sformatf("d%0d_error@%0h", id, addr), 32'(rsp_error[id]), 32'(exp_err));

    for (int c = 0; c < hold; c++) begin
      req_valid[id]   = 1'b1;
      req_write[id]   = 1'b1;
      req_size[id]    = 2'd2;
      req_address[id] = 32'h100;
      req_wdata[id]   = 32'hDEADBEEF;
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("d%0d_hold_valid", id), 32'(rsp_valid[id]), 32'h1);
      checkOutput($sformatf("d%0d_hold_rdata", id), rsp_rdata[id], exp_data);
      checkOutput($sformatf("d%0d_hold_ready", id), 32'(req_ready[id]), 32'h0);
    end
    req_valid[id] = 1'b0;

    rsp_ready[id] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[id] = 1'b0;
    checkOutput($sformatf("d%0d_rsp_done", id), 32'(rsp_valid[id]), 32'h0);
  endtask

  task automatic randomTraffic(input int id, input int n);
    logic [31:0] addr;
    logic [1:0]  size;
    for (int i = 0; i < n; i++) begin
      size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, depthOf(id) + 3));
      if ($urandom_range(0, 3) != 0) addr[1:0] = (size == 2'd1) ? {addr[1], 1'b0} :
                                                 (size == 2'd0) ? addr[1:0] : 2'b00;
      if ($urandom_range(0, 19) == 0) addr = $urandom;
      applyStimulus(id, 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)),
                    addr, $urandom, 0);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 1024; k++) model[d][k] = 8'h00;
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'd0;
      req_unsigned[d] = 1'b0; req_address[d] = 32'h0; req_wdata[d] = 32'h0;
      rsp_ready[d] = 1'b0;
    end
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("d%0d_rst_ready", d), 32'(req_ready[d]), 32'h0);
      checkOutput($sformatf("d%0d_rst_valid", d), 32'(rsp_valid[d]), 32'h0);
      checkOutput($sformatf("d%0d_rst_rdata", d), rsp_rdata[d], 32'h0);
      checkOutput($sformatf("d%0d_rst_error", d), 32'(rsp_error[d]), 32'h0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;

    applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 0);
    applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    applyStimulus(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0);
    applyStimulus(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h000000F0, 0);
    applyStimulus(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);
    applyStimulus(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
    applyStimulus(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0);
    applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 0);
    applyStimulus(0, 1'b1, 2'd1, 1'b0, 32'h3FF, 32'h0000ABCD, 0);
    applyStimulus(0, 1'b0, 2'd0, 1'b1, 32'h3FF, 32'h0, 0);
    applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h3FC, 32'hCAFEF00D, 0);
    applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 0);
    applyStimulus(0, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 0);
    applyStimulus(0, 1'b1, 2'd3, 1'b0, 32'h4, 32'h11223344, 0);
    applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 0);

    applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);
    applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);

    // Reset lands while the store is still in WAIT; the write itself must survive.
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_size[0] = 2'd2;
    req_unsigned[0] = 1'b0; req_address[0] = 32'h20; req_wdata[0] = 32'hAABBCCDD;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    model[0][32'h20] = 8'hAA; model[0][32'h21] = 8'hBB;
    model[0][32'h22] = 8'hCC; model[0][32'h23] = 8'hDD;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("midrst_ready", 32'(req_ready[0]), 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("midrst_valid", 32'(rsp_valid[0]), 32'h0);
      checkOutput("midrst_rdata", rsp_rdata[0], 32'h0);
      checkOutput("midrst_error", 32'(rsp_error[0]), 32'h0);
    end
    reset = 1'b0;
    #1;
    checkOutput("postrst_ready", 32'(req_ready[0]), 32'h1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("postrst_no_rsp", 32'(rsp_valid[0]), 32'h0);
    end
    applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);

    for (int d = 1; d < 3; d++) begin
      applyStimulus(d, 1'b1, 2'd2, 1'b0, 32'h3C, 32'h89ABCDEF, 0);
      applyStimulus(d, 1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, 0);
      applyStimulus(d, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0);
      applyStimulus(d, 1'b1, 2'd0, 1'b0, 32'h40, 32'h55, 0);
      applyStimulus(d, 1'b0, 2'd0, 1'b0, 32'h3F, 32'h0, 0);
      applyStimulus(d, 1'b0, 2'd1, 1'b1, 32'h3E, 32'h0, 2);
    end

    for (int d = 0; d < 3; d++) randomTraffic(d, 80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
